// File: rtl/seq_core_decode.sv
// Decode stage of a small 3-stage sequencer: splits the instruction register, resolves
// load-use hazards against stage 3, drives the fetch controls and registers the stage-3 packet.
module seq_core_decode #(
  parameter int A_SIZE = 10,
  parameter int D_SIZE = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ir,
  output logic [2:0]        rf_addr1,
  output logic [2:0]        rf_addr2,
  input  logic [D_SIZE-1:0] rf_data1,
  input  logic [D_SIZE-1:0] rf_data2,
  output logic              r2_pc_halt,
  output logic              r2_pc_load,
  output logic              r2_pc_loadr,
  output logic              r2_pc_flush,
  output logic [A_SIZE-1:0] r2_pc_target,
  output logic [3:0]        r3_op,
  output logic [2:0]        r3_dest,
  output logic              r3_wen,
  output logic              r3_mem_read,
  output logic              r3_mem_write,
  output logic [D_SIZE-1:0] r3_op1,
  output logic [D_SIZE-1:0] r3_op2
);

  typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;

  localparam logic [3:0] OP_LOADC = 4'h6;
  localparam logic [3:0] OP_LOAD  = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JMPR  = 4'hA;
  localparam logic [3:0] OP_JMPRZ = 4'hB;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t state_q, state_d;

  logic [3:0]        r3_op_q, r3_op_d;
  logic [2:0]        r3_dest_q, r3_dest_d;
  logic              r3_wen_q, r3_wen_d;
  logic              r3_mrd_q, r3_mrd_d;
  logic              r3_mwr_q, r3_mwr_d;
  logic [D_SIZE-1:0] r3_op1_q, r3_op1_d;
  logic [D_SIZE-1:0] r3_op2_q, r3_op2_d;

  logic [3:0]        op;
  logic [2:0]        d, s1, s2;
  logic [7:0]        imm8;
  logic [5:0]        off6;
  logic              use_s1, use_s2, hazard;
  logic [A_SIZE-1:0] rel_target;

  assign op         = ir[15:12];
  assign d          = ir[11:9];
  assign s1         = ir[8:6];
  assign s2         = ir[5:3];
  assign imm8       = ir[7:0];
  assign off6       = ir[5:0];
  assign rf_addr1   = s1;
  assign rf_addr2   = s2;
  assign rel_target = {{(A_SIZE-6){off6[5]}}, off6};

  always_comb begin
    use_s1 = 1'b0;
    use_s2 = 1'b0;
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, OP_STORE: begin
        use_s1 = 1'b1;
        use_s2 = 1'b1;
      end
      OP_LOAD, OP_JMP, OP_JMPRZ: use_s1 = 1'b1;
      default: ;
    endcase
  end

  assign hazard = r3_wen_q && ((use_s1 && (r3_dest_q == s1)) || (use_s2 && (r3_dest_q == s2)));

  // STALL shares the RUN decode path: the bubble now in stage 3 guarantees no hazard.
  always_comb begin
    state_d      = state_q;
    r2_pc_halt   = 1'b0;
    r2_pc_load   = 1'b0;
    r2_pc_loadr  = 1'b0;
    r2_pc_flush  = 1'b0;
    r2_pc_target = '0;
    r3_op_d      = '0;
    r3_dest_d    = '0;
    r3_wen_d     = 1'b0;
    r3_mrd_d     = 1'b0;
    r3_mwr_d     = 1'b0;
    r3_op1_d     = '0;
    r3_op2_d     = '0;
    if (!rst) begin
      case (state_q)
        RUN, STALL: begin
          state_d = RUN;
          if (hazard) begin
            r2_pc_halt = 1'b1;
            state_d    = STALL;
          end else if (op == OP_HALT) begin
            r2_pc_halt = 1'b1;
            state_d    = HALTED;
          end else if (op == OP_JMP) begin
            r2_pc_load   = 1'b1;
            r2_pc_flush  = 1'b1;
            r2_pc_target = rf_data1[A_SIZE-1:0];
          end else if (op == OP_JMPR || op == OP_JMPRZ) begin
            if (op == OP_JMPR || rf_data1 == '0) begin
              r2_pc_loadr  = 1'b1;
              r2_pc_flush  = 1'b1;
              r2_pc_target = rel_target;
            end
          end else begin
            r3_op_d   = op;
            r3_dest_d = d;
            r3_wen_d  = (op >= 4'h1) && (op <= OP_LOAD);
            r3_mrd_d  = (op == OP_LOAD);
            r3_mwr_d  = (op == OP_STORE);
            r3_op1_d  = rf_data1;
            r3_op2_d  = (op == OP_LOADC) ? {{(D_SIZE-8){1'b0}}, imm8} : rf_data2;
          end
        end
        HALTED: r2_pc_halt = 1'b1;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      r3_op_q   <= '0;
      r3_dest_q <= '0;
      r3_wen_q  <= 1'b0;
      r3_mrd_q  <= 1'b0;
      r3_mwr_q  <= 1'b0;
      r3_op1_q  <= '0;
      r3_op2_q  <= '0;
    end else begin
      state_q   <= state_d;
      r3_op_q   <= r3_op_d;
      r3_dest_q <= r3_dest_d;
      r3_wen_q  <= r3_wen_d;
      r3_mrd_q  <= r3_mrd_d;
      r3_mwr_q  <= r3_mwr_d;
      r3_op1_q  <= r3_op1_d;
      r3_op2_q  <= r3_op2_d;
    end
  end

  assign r3_op        = r3_op_q;
  assign r3_dest      = r3_dest_q;
  assign r3_wen       = r3_wen_q;
  assign r3_mem_read  = r3_mrd_q;
  assign r3_mem_write = r3_mwr_q;
  assign r3_op1       = r3_op1_q;
  assign r3_op2       = r3_op2_q;

endmodule

// File: tb/tb_seq_core_decode.sv
// Scoreboard bench for seq_core_decode: directed cases plus randomized instructions checked
// against an instruction-level reference model.
module tb_seq_core_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir = '0;
  logic [2:0]  rf_addr1, rf_addr2;
  logic [31:0] rf_data1 = '0, rf_data2 = '0;
  logic        r2_pc_halt, r2_pc_load, r2_pc_loadr, r2_pc_flush;
  logic [9:0]  r2_pc_target;
  logic [3:0]  r3_op;
  logic [2:0]  r3_dest;
  logic        r3_wen, r3_mem_read, r3_mem_write;
  logic [31:0] r3_op1, r3_op2;

  seq_core_decode #(.A_SIZE(10), .D_SIZE(32)) dut (
    .clk(clk), .rst(rst), .ir(ir),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2),
    .rf_data1(rf_data1), .rf_data2(rf_data2),
    .r2_pc_halt(r2_pc_halt), .r2_pc_load(r2_pc_load), .r2_pc_loadr(r2_pc_loadr),
    .r2_pc_flush(r2_pc_flush), .r2_pc_target(r2_pc_target),
    .r3_op(r3_op), .r3_dest(r3_dest), .r3_wen(r3_wen),
    .r3_mem_read(r3_mem_read), .r3_mem_write(r3_mem_write),
    .r3_op1(r3_op1), .r3_op2(r3_op2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       halt, load, loadr, flush;
    logic [9:0] target;
    logic [2:0] a1, a2;
  } comb_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  dest;
    logic        wen, mrd, mwr;
    logic [31:0] op1, op2;
  } r3_t;

  comb_t comb_q[$];
  r3_t   r3_q[$];
  int    total = 0;
  int    bad = 0;

  r3_t m_prev = '0;
  bit  m_halted = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endfunction

  // Instruction-level reference: which registers an opcode reads, what it does to fetch,
  // and what stage 3 should hold one cycle later.
  task automatic step(input logic r, input logic [15:0] i, input logic [31:0] d1, input logic [31:0] d2);
    comb_t c;
    r3_t   n;
    int    op, off;
    bit    rd1, rd2, haz;
    @(posedge clk);
    #2;
    rst = r; ir = i; rf_data1 = d1; rf_data2 = d2;
    c = '0; n = '0;
    c.a1 = i[8:6];
    c.a2 = i[5:3];
    op  = int'(i[15:12]);
    off = (int'(i[5:0]) >= 32) ? int'(i[5:0]) - 64 : int'(i[5:0]);
    if (r) begin
      m_halted = 1'b0;
    end else if (m_halted) begin
      c.halt = 1'b1;
    end else begin
      rd1 = (op >= 1 && op <= 5) || op == 7 || op == 8 || op == 9 || op == 11;
      rd2 = (op >= 1 && op <= 5) || op == 8;
      haz = m_prev.wen && ((rd1 && m_prev.dest == i[8:6]) || (rd2 && m_prev.dest == i[5:3]));
      if (haz) c.halt = 1'b1;
      else if (op == 15) begin
        c.halt = 1'b1;
        m_halted = 1'b1;
      end else if (op == 9) begin
        c.load = 1'b1; c.flush = 1'b1; c.target = d1[9:0];
      end else if (op == 10 || (op == 11 && d1 == 0)) begin
        c.loadr = 1'b1; c.flush = 1'b1; c.target = 10'(off);
      end else if (op != 11) begin
        n.op   = i[15:12];
        n.dest = i[11:9];
        n.wen  = op >= 1 && op <= 7;
        n.mrd  = op == 7;
        n.mwr  = op == 8;
        n.op1  = d1;
        n.op2  = (op == 6) ? 32'(i[7:0]) : d2;
      end
    end
    m_prev = n;
    comb_q.push_back(c);
    r3_q.push_back(n);
  endtask

  initial begin : comb_monitor
    comb_t e;
    forever begin
      @(negedge clk);
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        chk("pc_halt",   32'(r2_pc_halt),   32'(e.halt));
        chk("pc_load",   32'(r2_pc_load),   32'(e.load));
        chk("pc_loadr",  32'(r2_pc_loadr),  32'(e.loadr));
        chk("pc_flush",  32'(r2_pc_flush),  32'(e.flush));
        chk("pc_target", 32'(r2_pc_target), 32'(e.target));
        chk("rf_addr1",  32'(rf_addr1),     32'(e.a1));
        chk("rf_addr2",  32'(rf_addr2),     32'(e.a2));
      end
    end
  end

  initial begin : r3_monitor
    r3_t e;
    forever begin
      @(posedge clk);
      #1;
      if (r3_q.size() > 0) begin
        e = r3_q.pop_front();
        chk("r3_op",        32'(r3_op),        32'(e.op));
        chk("r3_dest",      32'(r3_dest),      32'(e.dest));
        chk("r3_wen",       32'(r3_wen),       32'(e.wen));
        chk("r3_mem_read",  32'(r3_mem_read),  32'(e.mrd));
        chk("r3_mem_write", 32'(r3_mem_write), 32'(e.mwr));
        chk("r3_op1",       r3_op1,            e.op1);
        chk("r3_op2",       r3_op2,            e.op2);
      end
    end
  end

  initial begin : stimulus
    logic [15:0] ri;
    logic [31:0] rd;
    step(1'b1, 16'h0000, 32'd0, 32'd0);
    step(1'b1, 16'h1250, 32'd9, 32'd9);
    // ADD issue, then LOADC followed by readers that do / do not use its destination
    step(1'b0, 16'h1250, 32'd5, 32'd7);
    step(1'b0, 16'h6A0F, 32'd1, 32'd2);
    step(1'b0, 16'h1A80, 32'd3, 32'd4);
    step(1'b0, 16'h6A0F, 32'd1, 32'd2);
    step(1'b0, 16'h1B40, 32'd15, 32'd4);
    step(1'b0, 16'h1B40, 32'd15, 32'd4);
    // relative jumps
    step(1'b0, 16'hA03E, 32'd0, 32'd0);
    step(1'b0, 16'h0000, 32'd0, 32'd0);
    step(1'b0, 16'hB0C3, 32'd0, 32'd8);
    step(1'b0, 16'hB0C3, 32'd1, 32'd8);
    step(1'b0, 16'h9040, 32'h1234_5678, 32'd0);
    // reset asserted during the stall cycle
    step(1'b0, 16'h6A0F, 32'd1, 32'd2);
    step(1'b0, 16'h1B40, 32'd6, 32'd4);
    step(1'b1, 16'h1B40, 32'd6, 32'd4);
    step(1'b0, 16'h1B40, 32'd6, 32'd4);
    // randomized traffic, no HALT, occasional reset
    for (int k = 0; k < 400; k++) begin
      ri = 16'($urandom);
      if (ri[15:12] == 4'hF) ri[15:12] = 4'h1;
      rd = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step($urandom_range(0, 39) == 0, ri, rd, $urandom);
    end
    // HALT holds for many cycles until reset
    step(1'b0, 16'h0000, 32'd0, 32'd0);
    step(1'b0, 16'hF000, 32'd0, 32'd0);
    for (int k = 0; k < 20; k++) step(1'b0, 16'($urandom), $urandom, $urandom);
    step(1'b1, 16'hF000, 32'd0, 32'd0);
    step(1'b0, 16'h1250, 32'd5, 32'd7);
    step(1'b0, 16'h0000, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #3;
    chk("comb_drain", 32'(comb_q.size()), 32'd0);
    chk("r3_drain",   32'(r3_q.size()),   32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
